alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Registered execute stage of the single-cycle RISC-V (RV32I) datapath. It combines ALU operation decoding (ALUOp/funct3/funct7), the 32-bit ALU, and the branch/jump taken decision. All outputs are registered and appear one clock after the operands are presented. It sits between the register-file/immediate operand muxes and the PC-select, data-memory and write-back logic.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  reset, asynchronous, active-low
- i_valid  in  1  operands and controls valid this cycle
- i_alu_op  in  3  class from main control: 000 ADD, 001 BRANCH, 010 R-type, 011 I-type ALU, 100 LUI, 101 JUMP
- i_funct3  in  3  instruction bits [14:12]
- i_funct7  in  7  instruction bits [31:25]; only bit 5 is used
- i_op1  in  XLEN  operand 1 (rs1 or PC)
- i_op2  in  XLEN  operand 2 (rs2 or immediate)
- i_branch  in  1  instruction is a conditional branch
- i_jump  in  1  instruction is JAL/JALR
- o_valid  out  1  registered copy of i_valid
- o_result  out  XLEN  ALU result
- o_zero  out  1  high when the ALU result equals 0
- o_alu_ctrl  out  4  decoded ALU control lines, for debug
- o_b_j_result  out  1  take the branch/jump target

## Operation
ALU control codes:
- 0000 AND, 0001 OR, 0010 ADD, 0011 XOR
- 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA
- 1000 SLT (signed), 1001 SLTU, 1010 PASS (result = op2)
- Any other code gives result 0.

ALUOp decode:
- 000 ADD and 101 JUMP decode to ADD.
- 100 LUI decodes to PASS.
- 001 BRANCH, by funct3:
  - 000/001 → SUB
  - 100/101 → SLT
  - 110/111 → SLTU
  - 010/011 → SUB
- 010 R-type, by funct3:
  - 000 → SUB if funct7[5]=1, else ADD
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR
  - 101 → SRA if funct7[5]=1, else SRL
  - 110 OR, 111 AND
- 011 I-type: same as R-type, except funct3 000 is always ADD; funct7[5] is used only for 101.
- 110 and 111 decode to ADD.

Arithmetic rules:
- ADD and SUB wrap modulo 2^32.
- Shift amount is op2[4:0]; SRA replicates op1[31].
- SLT and SLTU return 32'h1 or 32'h0.
- zero = (result == 0).

Branch/jump decision:
- b_j = i_jump | (i_branch & cond).
- cond by funct3:
  - 000 BEQ: zero
  - 001 BNE: !zero
  - 100 BLT, 110 BLTU: !zero
  - 101 BGE, 111 BGEU: zero
  - 010/011: 0
- When i_jump=1, b_j=1 regardless of i_branch and funct3.

## Timing
- Decode, ALU and branch logic are purely combinational from the inputs. All outputs come from flops.
- On each rising i_clk edge:
  - o_valid <= i_valid.
  - If i_valid=1: o_result, o_zero, o_alu_ctrl and o_b_j_result load the new values.
  - If i_valid=0: those four outputs hold, and o_b_j_result is forced to 0 so a stale taken decision is never presented.
- Latency is 1 cycle. Throughput is one operation per cycle, with no stall or handshake.
- Reset (asynchronous, any time, including mid-stream):
  - o_valid=0, o_result=0, o_zero=1, o_alu_ctrl=0010, o_b_j_result=0.
  - A valid input sampled on the first edge after deassertion is processed normally.

## Configuration
- EXU_SHIFT_EN defined: the barrel shifter is present and SLL/SRL/SRA behave as specified.
- EXU_SHIFT_EN undefined: the shifter is omitted. The codes 0100/0101/0111 are still decoded and reported on o_alu_ctrl, but give result 0 and zero=1.

## Test plan
- R-type SUB: alu_op=010, funct3=000, funct7=0100000, op1=5, op2=7. Next cycle: result=32'hFFFFFFFE, zero=0, ctrl=0110.
- I-type SRAI (EXU_SHIFT_EN defined): alu_op=011, funct3=101, funct7=0100000, op1=32'h80000000, op2=4. Result=32'hF8000000. The same input with funct7=0 (SRLI) gives 32'h08000000.
- BLT signed: branch=1, alu_op=001, funct3=100, op1=-1, op2=1. Result=1, b_j=1. The same with funct3=110 (BLTU): result=0, b_j=0.
- BEQ vs BNE: op1=op2=32'h1234. funct3=000 gives zero=1, b_j=1. funct3=001 gives b_j=0.
- JAL: jump=1, alu_op=101, op1=32'h100, op2=4. Result=32'h104, b_j=1. Then i_valid=0 on the next cycle: o_b_j_result=0, o_result holds 32'h104.
- Reset mid-stream: assert i_rstn=0 asynchronously between edges. All outputs immediately take their reset values. The first valid LUI after release (op2=32'hABCDE000) gives result=32'hABCDE000.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: operand/control bundle into the execute stage and the
// registered results coming back out. The master side is whoever supplies
// operands (decode/operand muxes); the slave side is the execute unit.
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic [2:0]      alu_op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            branch;
  logic            jump;

  logic            res_valid;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [3:0]      alu_ctrl;
  logic            b_j_result;

  modport master (
    output valid, alu_op, funct3, funct7, op1, op2, branch, jump,
    input  res_valid, result, zero, alu_ctrl, b_j_result
  );

  modport slave (
    input  valid, alu_op, funct3, funct7, op1, op2, branch, jump,
    output res_valid, result, zero, alu_ctrl, b_j_result
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered RV32I execute stage. Decodes ALUOp/funct3/funct7
// into ALU control lines, runs the 32-bit ALU and makes the branch/jump
// decision; every output comes from a flop one cycle after the operands.
// Optional feature macro: EXU_SHIFT_EN -- when defined the barrel shifter is
// built; when undefined, SLL/SRL/SRA still decode but produce a zero result.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  alu_exec_unit_if.slave bus
);

  localparam int SHAMT_W = $clog2(XLEN);

  typedef enum logic [3:0] {
    CTRL_AND  = 4'b0000,
    CTRL_OR   = 4'b0001,
    CTRL_ADD  = 4'b0010,
    CTRL_XOR  = 4'b0011,
    CTRL_SLL  = 4'b0100,
    CTRL_SRL  = 4'b0101,
    CTRL_SUB  = 4'b0110,
    CTRL_SRA  = 4'b0111,
    CTRL_SLT  = 4'b1000,
    CTRL_SLTU = 4'b1001,
    CTRL_PASS = 4'b1010
  } alu_ctrl_e;

  alu_ctrl_e       ctrl;
  logic [XLEN-1:0] alu_res;
  logic            alu_zero;
  logic            cond;
  logic            b_j;

  // Only funct7[5] distinguishes SUB/ADD and SRA/SRL; the rest is ignored.
  logic unused_funct7;
  assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

  // Translate the main-control class plus funct fields into ALU control lines.
  always_comb begin
    ctrl = CTRL_ADD;
    unique case (bus.alu_op)
      3'b001: begin
        case (bus.funct3)
          3'b100, 3'b101: ctrl = CTRL_SLT;
          3'b110, 3'b111: ctrl = CTRL_SLTU;
          default:        ctrl = CTRL_SUB;
        endcase
      end
      3'b010, 3'b011: begin
        case (bus.funct3)
          3'b000:  ctrl = (bus.alu_op == 3'b010 && bus.funct7[5]) ? CTRL_SUB : CTRL_ADD;
          3'b001:  ctrl = CTRL_SLL;
          3'b010:  ctrl = CTRL_SLT;
          3'b011:  ctrl = CTRL_SLTU;
          3'b100:  ctrl = CTRL_XOR;
          3'b101:  ctrl = bus.funct7[5] ? CTRL_SRA : CTRL_SRL;
          3'b110:  ctrl = CTRL_OR;
          default: ctrl = CTRL_AND;
        endcase
      end
      3'b100:  ctrl = CTRL_PASS;
      default: ctrl = CTRL_ADD;
    endcase
  end

  // 32-bit ALU; shifts exist only when the shifter is built in.
  always_comb begin
    alu_res = '0;
    case (ctrl)
      CTRL_AND:  alu_res = bus.op1 & bus.op2;
      CTRL_OR:   alu_res = bus.op1 | bus.op2;
      CTRL_ADD:  alu_res = bus.op1 + bus.op2;
      CTRL_XOR:  alu_res = bus.op1 ^ bus.op2;
      CTRL_SUB:  alu_res = bus.op1 - bus.op2;
`ifdef EXU_SHIFT_EN
      CTRL_SLL:  alu_res = bus.op1 << bus.op2[SHAMT_W-1:0];
      CTRL_SRL:  alu_res = bus.op1 >> bus.op2[SHAMT_W-1:0];
      CTRL_SRA:  alu_res = $unsigned($signed(bus.op1) >>> bus.op2[SHAMT_W-1:0]);
`endif
      CTRL_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.op1) < $signed(bus.op2))};
      CTRL_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.op1 < bus.op2)};
      CTRL_PASS: alu_res = bus.op2;
      default:   alu_res = '0;
    endcase
  end

  // Branch condition from the zero flag, then fold in unconditional jumps.
  always_comb begin
    alu_zero = (alu_res == '0);
    case (bus.funct3)
      3'b000, 3'b101, 3'b111: cond = alu_zero;
      3'b001, 3'b100, 3'b110: cond = !alu_zero;
      default:                cond = 1'b0;
    endcase
    b_j = bus.jump | (bus.branch & cond);
  end

  // Output register: hold results on idle cycles but never a taken decision.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      bus.res_valid  <= 1'b0;
      bus.result     <= '0;
      bus.zero       <= 1'b1;
      bus.alu_ctrl   <= CTRL_ADD;
      bus.b_j_result <= 1'b0;
    end else begin
      bus.res_valid <= bus.valid;
      if (bus.valid) begin
        bus.result     <= alu_res;
        bus.zero       <= alu_zero;
        bus.alu_ctrl   <= ctrl;
        bus.b_j_result <= b_j;
      end else begin
        bus.b_j_result <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against
// an instruction-level reference model. Follows EXU_SHIFT_EN like the design.
module tb_alu_exec_unit;

`ifdef EXU_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  logic        exp_valid;
  logic [31:0] exp_result;
  logic        exp_zero;
  logic [3:0]  exp_ctrl;
  logic        exp_bj;

  alu_exec_unit_if #(.XLEN(32)) bus ();

  alu_exec_unit #(.XLEN(32)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: pick the operation the instruction means, then evaluate it.
  function automatic void ref_alu(input logic [2:0] aop, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [31:0] a,
                                  input logic [31:0] b, output logic [3:0] code,
                                  output logic [31:0] res);
    int unsigned sh;
    sh   = b % 32;
    code = 4'd2;
    if (aop == 3'd1) begin
      if (f3 == 3'd4 || f3 == 3'd5)      code = 4'd8;
      else if (f3 == 3'd6 || f3 == 3'd7) code = 4'd9;
      else                                code = 4'd6;
    end else if (aop == 3'd4) begin
      code = 4'd10;
    end else if (aop == 3'd2 || aop == 3'd3) begin
      case (f3)
        3'd0: code = (aop == 3'd2 && f7[5]) ? 4'd6 : 4'd2;
        3'd1: code = 4'd4;
        3'd2: code = 4'd8;
        3'd3: code = 4'd9;
        3'd4: code = 4'd3;
        3'd5: code = f7[5] ? 4'd7 : 4'd5;
        3'd6: code = 4'd1;
        default: code = 4'd0;
      endcase
    end
    case (code)
      4'd0:  res = a & b;
      4'd1:  res = a | b;
      4'd2:  res = 32'(longint'(a) + longint'(b));
      4'd3:  res = a ^ b;
      4'd4:  res = SHIFT_EN ? 32'(longint'(a) * (longint'(1) << sh)) : 32'h0;
      4'd5:  res = SHIFT_EN ? 32'(longint'(a) / (longint'(1) << sh)) : 32'h0;
      4'd6:  res = 32'(longint'(a) + longint'(~b) + 1);
      4'd7:  res = SHIFT_EN ? ((a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0)) : 32'h0;
      4'd8:  res = (longint'(int'(a)) < longint'(int'(b))) ? 32'h1 : 32'h0;
      4'd9:  res = (longint'(a) < longint'(b)) ? 32'h1 : 32'h0;
      4'd10: res = b;
      default: res = 32'h0;
    endcase
  endfunction

  // Reference: whether a conditional branch with these operands is taken.
  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) < int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one operation at a falling edge, update the model, sample a cycle later.
  task automatic apply(input logic v, input logic [2:0] aop, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                       input logic br, input logic jmp);
    logic [3:0]  code;
    logic [31:0] res;
    bus.valid  = v;
    bus.alu_op = aop;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.op1    = a;
    bus.op2    = b;
    bus.branch = br;
    bus.jump   = jmp;
    ref_alu(aop, f3, f7, a, b, code, res);
    exp_valid = v;
    if (v) begin
      exp_result = res;
      exp_zero   = (res == 32'h0);
      exp_ctrl   = code;
      exp_bj     = jmp | (br & ref_taken(f3, a, b));
    end else begin
      exp_bj = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    exp_valid  = 1'b0;
    exp_result = 32'h0;
    exp_zero   = 1'b1;
    exp_ctrl   = 4'b0010;
    exp_bj     = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.valid = 1'b0; bus.alu_op = 3'd0; bus.funct3 = 3'd0; bus.funct7 = 7'd0;
    bus.op1 = 32'h0; bus.op2 = 32'h0; bus.branch = 1'b0; bus.jump = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.res_valid); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", bus.result); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b expected 1", bus.zero); end
    checks++; if (bus.alu_ctrl !== 4'b0010) begin errors++; $display("FAIL reset_ctrl: got %b expected 0010", bus.alu_ctrl); end
    checks++; if (bus.b_j_result !== 1'b0) begin errors++; $display("FAIL reset_bj: got %b expected 0", bus.b_j_result); end
    rstn = 1'b1;
  endtask

  task automatic test_rtype_sub();
    apply(1'b1, 3'b010, 3'b000, 7'b0100000, 32'd5, 32'd7, 1'b0, 1'b0);
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL sub_valid: got %b expected 1", bus.res_valid); end
    checks++; if (bus.result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_result: got %h expected fffffffe", bus.result); end
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL sub_zero: got %b expected 0", bus.zero); end
    checks++; if (bus.alu_ctrl !== 4'b0110) begin errors++; $display("FAIL sub_ctrl: got %b expected 0110", bus.alu_ctrl); end
  endtask

  task automatic test_shift_imm();
    logic [31:0] want;
    want = SHIFT_EN ? 32'hF800_0000 : 32'h0;
    apply(1'b1, 3'b011, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4, 1'b0, 1'b0);
    checks++; if (bus.result !== want) begin errors++; $display("FAIL srai_result: got %h expected %h", bus.result, want); end
    checks++; if (bus.alu_ctrl !== 4'b0111) begin errors++; $display("FAIL srai_ctrl: got %b expected 0111", bus.alu_ctrl); end
    checks++; if (bus.zero !== !SHIFT_EN) begin errors++; $display("FAIL srai_zero: got %b expected %b", bus.zero, !SHIFT_EN); end
    want = SHIFT_EN ? 32'h0800_0000 : 32'h0;
    apply(1'b1, 3'b011, 3'b101, 7'b0000000, 32'h8000_0000, 32'd4, 1'b0, 1'b0);
    checks++; if (bus.result !== want) begin errors++; $display("FAIL srli_result: got %h expected %h", bus.result, want); end
    checks++; if (bus.alu_ctrl !== 4'b0101) begin errors++; $display("FAIL srli_ctrl: got %b expected 0101", bus.alu_ctrl); end
  endtask

  task automatic test_branches();
    apply(1'b1, 3'b001, 3'b100, 7'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    checks++; if (bus.result !== 32'h1) begin errors++; $display("FAIL blt_result: got %h expected 00000001", bus.result); end
    checks++; if (bus.b_j_result !== 1'b1) begin errors++; $display("FAIL blt_bj: got %b expected 1", bus.b_j_result); end
    apply(1'b1, 3'b001, 3'b110, 7'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL bltu_result: got %h expected 00000000", bus.result); end
    checks++; if (bus.b_j_result !== 1'b0) begin errors++; $display("FAIL bltu_bj: got %b expected 0", bus.b_j_result); end
    checks++; if (bus.alu_ctrl !== 4'b1001) begin errors++; $display("FAIL bltu_ctrl: got %b expected 1001", bus.alu_ctrl); end
    apply(1'b1, 3'b001, 3'b000, 7'd0, 32'h1234, 32'h1234, 1'b1, 1'b0);
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL beq_zero: got %b expected 1", bus.zero); end
    checks++; if (bus.b_j_result !== 1'b1) begin errors++; $display("FAIL beq_bj: got %b expected 1", bus.b_j_result); end
    apply(1'b1, 3'b001, 3'b001, 7'd0, 32'h1234, 32'h1234, 1'b1, 1'b0);
    checks++; if (bus.b_j_result !== 1'b0) begin errors++; $display("FAIL bne_bj: got %b expected 0", bus.b_j_result); end
  endtask

  task automatic test_jump_then_idle();
    apply(1'b1, 3'b101, 3'b000, 7'd0, 32'h100, 32'd4, 1'b0, 1'b1);
    checks++; if (bus.result !== 32'h104) begin errors++; $display("FAIL jal_result: got %h expected 00000104", bus.result); end
    checks++; if (bus.b_j_result !== 1'b1) begin errors++; $display("FAIL jal_bj: got %b expected 1", bus.b_j_result); end
    apply(1'b0, 3'b101, 3'b000, 7'd0, 32'h100, 32'd4, 1'b0, 1'b1);
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", bus.res_valid); end
    checks++; if (bus.b_j_result !== 1'b0) begin errors++; $display("FAIL idle_bj: got %b expected 0", bus.b_j_result); end
    checks++; if (bus.result !== 32'h104) begin errors++; $display("FAIL idle_hold: got %h expected 00000104", bus.result); end
  endtask

  task automatic test_midstream_reset();
    apply(1'b1, 3'b000, 3'b000, 7'd0, 32'h55, 32'h66, 1'b0, 1'b1);
    bus.op1 = 32'h77;
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", bus.res_valid); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL rst_mid_result: got %h expected 00000000", bus.result); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL rst_mid_zero: got %b expected 1", bus.zero); end
    checks++; if (bus.alu_ctrl !== 4'b0010) begin errors++; $display("FAIL rst_mid_ctrl: got %b expected 0010", bus.alu_ctrl); end
    checks++; if (bus.b_j_result !== 1'b0) begin errors++; $display("FAIL rst_mid_bj: got %b expected 0", bus.b_j_result); end
    @(negedge clk);
    rstn = 1'b1;
    apply(1'b1, 3'b100, 3'b000, 7'd0, 32'h0, 32'hABCD_E000, 1'b0, 1'b0);
    checks++; if (bus.result !== 32'hABCD_E000) begin errors++; $display("FAIL lui_result: got %h expected abcde000", bus.result); end
    checks++; if (bus.alu_ctrl !== 4'b1010) begin errors++; $display("FAIL lui_ctrl: got %b expected 1010", bus.alu_ctrl); end
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL lui_valid: got %b expected 1", bus.res_valid); end
  endtask

  // Random back-to-back stream with idle gaps, every output against the model.
  task automatic test_random_stream();
    logic        v, br, jmp;
    logic [2:0]  aop, f3;
    logic [6:0]  f7;
    logic [31:0] a, b;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 4) != 0);
      jmp = ($urandom_range(0, 7) == 0);
      br  = ($urandom_range(0, 3) == 0);
      aop = br ? 3'b001 : 3'($urandom_range(0, 7));
      f3  = 3'($urandom_range(0, 7));
      f7  = {1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31))};
      a   = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = 32'($urandom_range(0, 40));
        2: b = a + 32'($urandom_range(0, 2)) - 32'd1;
        default: b = $urandom;
      endcase
      apply(v, aop, f3, f7, a, b, br, jmp);
      checks++; if (bus.res_valid !== exp_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, bus.res_valid, exp_valid); end
      checks++; if (bus.result !== exp_result) begin errors++; $display("FAIL rand_result[%0d]: got %h expected %h (op %b f3 %b)", i, bus.result, exp_result, aop, f3); end
      checks++; if (bus.zero !== exp_zero) begin errors++; $display("FAIL rand_zero[%0d]: got %b expected %b", i, bus.zero, exp_zero); end
      checks++; if (bus.alu_ctrl !== exp_ctrl) begin errors++; $display("FAIL rand_ctrl[%0d]: got %b expected %b", i, bus.alu_ctrl, exp_ctrl); end
      checks++; if (bus.b_j_result !== exp_bj) begin errors++; $display("FAIL rand_bj[%0d]: got %b expected %b", i, bus.b_j_result, exp_bj); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    $display("[TB] starting, shifter enabled = %0d", SHIFT_EN);
    test_reset();
    @(negedge clk);
    test_rtype_sub();
    test_shift_imm();
    test_branches();
    test_jump_then_idle();
    test_midstream_reset();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
